// File: rtl/fifo_pkg.sv
// Shared types and default constants for the FIFO reader and its output buffer.
package fifo_pkg;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_BURST_LEN = 4;
  localparam int unsigned WS_W          = 16;
  localparam int unsigned OCC_W         = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Width of a counter that spans 0..n-1 (at least one bit).
  function automatic int unsigned beat_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// Two-entry in-order skid buffer between the upstream FIFO read data and the
// downstream stream port.
//   clk, reset : clock, synchronous active-high reset
//   i_push     : write i_data into the tail entry
//   i_pop      : retire the head entry
//   i_data     : word to store
//   o_occ      : number of stored words (0..2)
//   o_head     : oldest stored word
module fifo_reader_buf
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [OCC_W-1:0] o_occ,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_head_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             w_tail_ptr;

  // Tail sits next to the head once one word is stored.
  assign w_tail_ptr = r_head_ptr ^ r_occ[0];

  // Storage, head pointer and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_head_ptr <= 1'b0;
      r_occ      <= '0;
    end else begin
      if (i_push) begin
        r_mem[w_tail_ptr] <= i_data;
      end
      if (i_pop) begin
        r_head_ptr <= ~r_head_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_mem[r_head_ptr];

endmodule

// File: rtl/fifo_reader.sv
// Pulls words from an upstream FIFO (one-cycle read latency) and presents
// them as a valid/ready stream with burst framing and a sent-word counter.
//   clk, reset   : clock, synchronous active-high reset
//   enable       : permit new FIFO reads
//   fifo_empty   : upstream empty flag
//   fifo_data    : upstream read data, valid the cycle after fifo_rd
//   fifo_rd      : upstream read strobe
//   m_valid/m_ready/m_data/m_last : downstream stream
//   busy         : FSM not idle
//   words_sent   : accepted beats, modulo 2^16
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic            fifo_rd,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic            m_last,
  output logic            busy,
  output logic [WS_W-1:0] words_sent
);

  localparam int unsigned     BEAT_W    = beat_width(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_in_flight;
  logic [BEAT_W-1:0] r_beat;
  logic [WS_W-1:0]  r_words_sent;
  logic [OCC_W-1:0] w_occ;
  logic [WIDTH-1:0] w_head;
  logic             w_pop;
  logic             w_room;
  logic [2:0]       w_pending;

  fifo_reader_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk    (clk),
    .reset  (reset),
    .i_push (r_in_flight),
    .i_pop  (w_pop),
    .i_data (fifo_data),
    .o_occ  (w_occ),
    .o_head (w_head)
  );

  assign m_valid = (w_occ != '0);
  assign w_pop   = m_valid && m_ready;

  // occ + in_flight - pop < 2, rearranged so nothing underflows.
  assign w_pending = 3'(w_occ) + 3'(r_in_flight);
  assign w_room    = w_pending < (3'd2 + 3'(w_pop));

  // Next state and read strobe; reset blocks a read that would be discarded.
  always_comb begin
    w_state_nxt = r_state;
    fifo_rd     = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) w_state_nxt = RUN;
      end
      RUN: begin
        fifo_rd = !reset && !fifo_empty && w_room;
        if (!enable) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (enable) begin
          w_state_nxt = RUN;
        end else if (!r_in_flight && (w_occ == '0)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, in-flight tracking, burst beat and sent-word counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_in_flight  <= 1'b0;
      r_beat       <= '0;
      r_words_sent <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_flight <= fifo_rd;
      if (w_pop) begin
        r_beat       <= (r_beat == LAST_BEAT) ? '0 : r_beat + BEAT_W'(1);
        r_words_sent <= r_words_sent + WS_W'(1);
      end
    end
  end

  assign m_data     = w_head;
  assign m_last     = m_valid && (r_beat == LAST_BEAT);
  assign busy       = (r_state != IDLE);
  assign words_sent = r_words_sent;

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;
  import fifo_pkg::*;

  localparam int unsigned W     = 32;
  localparam int          BL    = 4;
  localparam int          MEM_N = 1 << 17;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          fifo_empty;
  logic [W-1:0]  fifo_data;
  logic          fifo_rd;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          busy;
  logic [15:0]   words_sent;

  fifo_reader #(.WIDTH(W), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .words_sent (words_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream FIFO model: contents in fifo_mem[rd_ptr..wr_ptr-1].
  logic [W-1:0] fifo_mem [MEM_N];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int exp_ptr = 0;
  int mbeat = 0;
  logic empty_gate = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr) || empty_gate;

  initial fifo_data = '0;
  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_data <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Negedge sample: protocol check plus in-order scoreboard.
  task automatic sample();
    @(negedge clk);
    if (!reset) begin
      if (fifo_empty) chk("rd_while_empty", 32'(fifo_rd), 32'd0);
      if (m_valid && m_ready) begin
        chk("sb_data", m_data, fifo_mem[exp_ptr]);
        chk("sb_last", 32'(m_last), (mbeat == BL - 1) ? 32'd1 : 32'd0);
        exp_ptr++;
        mbeat = (mbeat == BL - 1) ? 0 : mbeat + 1;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  // Reset, then discard anything left in the model FIFO.
  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    m_ready = 1'b0;
    empty_gate = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    wr_ptr = rd_ptr;
    exp_ptr = rd_ptr;
    mbeat = 0;
  endtask

  task automatic load(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) fifo_mem[wr_ptr + i] = base + 32'(i);
    wr_ptr += n;
  endtask

  typedef struct {
    logic        en;
    logic        rdy;
    logic        rd;
    logic        vld;
    logic [31:0] data;
    logic        last;
    logic        bsy;
    logic [15:0] ws;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic rdy, input logic rd, input logic vld,
                              input logic [31:0] d, input logic l, input logic b,
                              input logic [15:0] ws);
    vec_t v;
    v.en = en; v.rdy = rdy; v.rd = rd; v.vld = vld;
    v.data = d; v.last = l; v.bsy = b; v.ws = ws;
    return v;
  endfunction

  vec_t vt [15];

  initial begin : main
    int start;
    int rd_cnt;
    reset = 1'b1;
    enable = 1'b0;
    m_ready = 1'b0;

    // 8-word stream with m_ready high: startup latency, framing, counter.
    vt[0]  = mk(1, 1, 0, 0, 32'h0, 0, 0, 16'd0);
    vt[1]  = mk(1, 1, 1, 0, 32'h0, 0, 1, 16'd0);
    vt[2]  = mk(1, 1, 1, 0, 32'h0, 0, 1, 16'd0);
    vt[3]  = mk(1, 1, 1, 1, 32'h1, 0, 1, 16'd0);
    vt[4]  = mk(1, 1, 1, 1, 32'h2, 0, 1, 16'd1);
    vt[5]  = mk(1, 1, 1, 1, 32'h3, 0, 1, 16'd2);
    vt[6]  = mk(1, 1, 1, 1, 32'h4, 1, 1, 16'd3);
    vt[7]  = mk(1, 1, 1, 1, 32'h5, 0, 1, 16'd4);
    vt[8]  = mk(1, 1, 1, 1, 32'h6, 0, 1, 16'd5);
    vt[9]  = mk(1, 1, 0, 1, 32'h7, 0, 1, 16'd6);
    vt[10] = mk(1, 1, 0, 1, 32'h8, 1, 1, 16'd7);
    vt[11] = mk(1, 1, 0, 0, 32'h0, 0, 1, 16'd8);
    vt[12] = mk(0, 1, 0, 0, 32'h0, 0, 1, 16'd8);
    vt[13] = mk(0, 1, 0, 0, 32'h0, 0, 1, 16'd8);
    vt[14] = mk(0, 1, 0, 0, 32'h0, 0, 0, 16'd8);

    do_reset();
    sample();
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ws", 32'(words_sent), 32'd0);
    chk("rst_rd", 32'(fifo_rd), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_data", m_data, 32'd0);
    advance();

    load(8, 32'h1);
    for (int i = 0; i < 15; i++) begin
      enable = vt[i].en;
      m_ready = vt[i].rdy;
      sample();
      chk($sformatf("v%0d_rd", i), 32'(fifo_rd), 32'(vt[i].rd));
      chk($sformatf("v%0d_valid", i), 32'(m_valid), 32'(vt[i].vld));
      if (vt[i].vld) chk($sformatf("v%0d_data", i), m_data, vt[i].data);
      chk($sformatf("v%0d_last", i), 32'(m_last), 32'(vt[i].last));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].bsy));
      chk($sformatf("v%0d_ws", i), 32'(words_sent), 32'(vt[i].ws));
      advance();
    end

    // Backpressure: only two reads fit, head word held stable.
    do_reset();
    load(4, 32'h10);
    enable = 1'b1;
    m_ready = 1'b0;
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (fifo_rd) rd_cnt++;
      if (m_valid) chk("bp_hold_data", m_data, 32'h10);
      advance();
    end
    sample();
    chk("bp_rd_pulses", 32'(rd_cnt), 32'd2);
    chk("bp_occ", 32'(dut.w_occ), 32'd2);
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_rd_now", 32'(fifo_rd), 32'd0);
    advance();
    start = exp_ptr;
    m_ready = 1'b1;
    for (int i = 0; i < 20 && (exp_ptr - start) < 4; i++) tick();
    chk("bp_delivered", 32'(exp_ptr - start), 32'd4);

    // Toggling m_ready and a flickering empty flag.
    do_reset();
    load(12, 32'hA00);
    start = exp_ptr;
    enable = 1'b1;
    for (int c = 0; c < 200 && (exp_ptr - start) < 12; c++) begin
      m_ready = (c % 2 == 0);
      empty_gate = ((c / 3) % 2) == 1;
      tick();
    end
    empty_gate = 1'b0;
    chk("toggle_delivered", 32'(exp_ptr - start), 32'd12);

    // Drop enable with one word buffered and one in flight.
    do_reset();
    load(4, 32'h100);
    start = exp_ptr;
    enable = 1'b1;
    m_ready = 1'b0;
    tick(); tick(); tick();
    enable = 1'b0;
    sample();
    chk("drain_inflight", 32'(dut.r_in_flight), 32'd1);
    chk("drain_occ", 32'(dut.w_occ), 32'd1);
    chk("drain_pre_state", 32'(dut.r_state), 32'(RUN));
    advance();
    m_ready = 1'b1;
    sample();
    chk("drain_state", 32'(dut.r_state), 32'(DRAIN));
    chk("drain_rd", 32'(fifo_rd), 32'd0);
    advance();
    for (int i = 0; i < 10 && busy; i++) tick();
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_idle", 32'(dut.r_state), 32'(IDLE));
    chk("drain_delivered", 32'(exp_ptr - start), 32'd2);

    // Mid-operation reset with a full buffer and words_sent = 5.
    do_reset();
    load(5, 32'h200);
    enable = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 40 && !(words_sent == 16'd5 && !m_valid); i++) tick();
    load(3, 32'h300);
    m_ready = 1'b0;
    repeat (5) tick();
    sample();
    chk("mr_occ", 32'(dut.w_occ), 32'd2);
    chk("mr_ws", 32'(words_sent), 32'd5);
    chk("mr_head", m_data, 32'h300);
    advance();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    enable = 1'b0;
    sample();
    chk("mr_valid", 32'(m_valid), 32'd0);
    chk("mr_ws0", 32'(words_sent), 32'd0);
    chk("mr_beat", 32'(dut.r_beat), 32'd0);
    chk("mr_state", 32'(dut.r_state), 32'(IDLE));
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_data", m_data, 32'd0);
    advance();

    // words_sent wraps 0xFFFF -> 0.
    do_reset();
    load(65534, 32'h5000_0000);
    start = exp_ptr;
    enable = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 70000 && !(words_sent == 16'hFFFE && !m_valid); i++) tick();
    chk("wrap_pre", 32'(words_sent), 32'hFFFE);
    load(3, 32'h6000_0000);
    for (int i = 0; i < 20 && !(words_sent == 16'h0001 && !m_valid); i++) tick();
    chk("wrap_post", 32'(words_sent), 32'h0001);
    chk("wrap_count", 32'(exp_ptr - start), 32'd65537);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
